// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point divider.
//   - FP32 field widths, exponent bias and the special result constants
//   - FSM state encoding and operand special-class encoding
//   - classify(): maps an FP32 word onto its special class
package fp_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    // Internal exponent: wide enough for ea - eb + BIAS over all normal
    // inputs (-126 .. 380) plus one step either way from normalisation.
    localparam int SEXP_W = 10;

    typedef logic [SIGN_W+EXP_W+FRAC_W-1:0] fp32_t;
    typedef logic signed [SEXP_W-1:0]       sexp_t;

    localparam fp32_t QNAN = 32'h7FC0_0000;
    localparam fp32_t PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        C_ZERO,
        C_INF,
        C_NAN,
        C_NORMAL
    } fp_class_e;

    // Denormals are flushed: any zero exponent field counts as zero.
    function automatic fp_class_e classify(input fp32_t x);
        if (x[FRAC_W +: EXP_W] == '0) begin
            return C_ZERO;
        end
        if (x[FRAC_W +: EXP_W] == '1) begin
            return (x[FRAC_W-1:0] == '0) ? C_INF : C_NAN;
        end
        return C_NORMAL;
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/busy/done handshake between the ALU top and the sequential divider.
//   start     : request a division (master -> slave)
//   a, b      : FP32 dividend / divisor (master -> slave)
//   busy      : divider working (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   result    : FP32 quotient, held until the next done (slave -> master)
//   exception : special input, overflow or underflow (slave -> master)
interface fp_div_seq_if;

    logic          start;
    fp_pkg::fp32_t a;
    fp_pkg::fp32_t b;
    logic          busy;
    logic          done;
    fp_pkg::fp32_t result;
    logic          exception;

    modport master (
        output start, a, b,
        input  busy, done, result, exception
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, exception
    );

endinterface

// File: rtl/fp_div_round_pack.sv
// Combinational normalise / round-to-nearest-even / pack stage of the divider.
//   q         : raw quotient, integer bit at the MSB, then fraction, guard, extra
//   rem_nz    : final partial remainder is non-zero (folds into sticky)
//   sign      : result sign
//   exp_in    : biased exponent before normalisation (signed)
//   result    : packed FP32 quotient (+-inf on overflow, +-0 on underflow)
//   range_exc : overflow or underflow occurred
module fp_div_round_pack
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic [QBITS-1:0] q,
    input  logic             rem_nz,
    input  logic             sign,
    input  sexp_t            exp_in,
    output fp32_t            result,
    output logic             range_exc
);

    logic [FRAC_W-1:0] frac;
    logic [FRAC_W:0]   frac_rnd;   // carry-out in the MSB
    logic              guard;
    logic              sticky;
    logic              round_up;
    sexp_t             exp_norm;
    sexp_t             exp_fin;

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        frac     = q[QBITS-2 -: FRAC_W];
        guard    = q[QBITS-25];
        sticky   = q[QBITS-26] | rem_nz;
        exp_norm = exp_in;

        // Quotient below 1.0: the leading one sits one place lower.
        if (!q[QBITS-1]) begin
            frac     = q[QBITS-3 -: FRAC_W];
            guard    = q[QBITS-26];
            sticky   = rem_nz;
            exp_norm = exp_in - sexp_t'(1);
        end

        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};

        // A carry-out leaves the fraction bits at zero; only bump the exponent.
        exp_fin = frac_rnd[FRAC_W] ? exp_norm + sexp_t'(1) : exp_norm;

        result    = {sign, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
        range_exc = 1'b0;

        if (exp_fin >= sexp_t'(255)) begin
            result    = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            range_exc = 1'b1;
        end else if (exp_fin <= sexp_t'(0)) begin
            result    = {sign, {(EXP_W+FRAC_W){1'b0}}};
            range_exc = 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// One restoring-division quotient bit per clock, then normalise, round to
// nearest-even and pack. Special operands bypass the iteration.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : start/a/b in; busy/done/result/exception out (slave modport)
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int QBITS = 26,
    parameter int BIAS  = EXP_BIAS
) (
    input logic         clk,
    input logic         reset,
    fp_div_seq_if.slave bus
);

    localparam int             CNT_W    = $clog2(QBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);
    localparam sexp_t          BIAS_S   = sexp_t'(BIAS);

    state_e state_q, state_d;

    // Operation registers.
    logic              sign_q;
    logic [FRAC_W:0]   mb_q;        // divisor mantissa with hidden one
    sexp_t             exp_q;
    logic [FRAC_W+1:0] rem_q;       // partial remainder, one bit wider than mb_q
    logic [QBITS-1:0]  quo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              special_q;
    fp32_t             pre_res_q;   // preset result for special operands
    fp32_t             result_q;
    logic              exc_q;

    // Operand classification, evaluated while IDLE.
    fp_class_e cls_a, cls_b;
    logic      sign_in;
    logic      sp_any;
    fp32_t     sp_res;
    sexp_t     exp_diff;

    always_comb begin
        cls_a   = classify(bus.a);
        cls_b   = classify(bus.b);
        sign_in = bus.a[SIGN_W+EXP_W+FRAC_W-1] ^ bus.b[SIGN_W+EXP_W+FRAC_W-1];
        sp_any  = (cls_a != C_NORMAL) || (cls_b != C_NORMAL);

        if ((cls_a == C_NAN) || (cls_b == C_NAN) ||
            ((cls_a == C_ZERO) && (cls_b == C_ZERO)) ||
            ((cls_a == C_INF) && (cls_b == C_INF))) begin
            sp_res = QNAN;
        end else if ((cls_a == C_INF) || (cls_b == C_ZERO)) begin
            sp_res = PINF | {sign_in, {(EXP_W+FRAC_W){1'b0}}};
        end else begin
            sp_res = {sign_in, {(EXP_W+FRAC_W){1'b0}}};
        end

        exp_diff = $signed({2'b00, bus.a[FRAC_W +: EXP_W]})
                 - $signed({2'b00, bus.b[FRAC_W +: EXP_W]})
                 + BIAS_S;
    end

    // One restoring step. After a subtract the remainder is below mb_q, so the
    // left shift never loses a set bit.
    logic              q_bit;
    logic [FRAC_W+1:0] rem_sub;
    logic [FRAC_W+1:0] rem_nxt;

    always_comb begin
        q_bit   = (rem_q >= {1'b0, mb_q});
        rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_nxt = rem_sub << 1;
    end

    fp32_t rp_result;
    logic  rp_exc;

    fp_div_round_pack #(
        .QBITS (QBITS)
    ) u_round_pack (
        .q         (quo_q),
        .rem_nz    (|rem_q),
        .sign      (sign_q),
        .exp_in    (exp_q),
        .result    (rp_result),
        .range_exc (rp_exc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic busy_d;
    logic done_d;

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = sp_any ? S_NORM : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                busy_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset along with the state so that an
    // abort mid-division leaves no stale operand or result visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q    <= 1'b0;
            mb_q      <= '0;
            exp_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
            pre_res_q <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sign_q    <= sign_in;
                        mb_q      <= {1'b1, bus.b[FRAC_W-1:0]};
                        exp_q     <= exp_diff;
                        rem_q     <= {2'b01, bus.a[FRAC_W-1:0]};
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        special_q <= sp_any;
                        pre_res_q <= sp_res;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[QBITS-2:0], q_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_NORM: begin
                    if (special_q) begin
                        result_q <= pre_res_q;
                        exc_q    <= 1'b1;
                    end else begin
                        result_q <= rp_result;
                        exc_q    <= rp_exc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_d;
    assign bus.done      = done_d;
    assign bus.result    = result_q;
    assign bus.exception = exc_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq. The driver pushes each expected
// response when start is accepted; an independent monitor pops and compares
// on every done pulse, including latency and busy-cycle count.
module tb_fp_div_seq;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];

    fp_div_seq_if bus ();

    fp_div_seq #(
        .QBITS (26),
        .BIAS  (127)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic expect_op(input logic [31:0] r, input logic x, input int lat);
        exp_t e;
        e.res = r;
        e.exc = x;
        e.lat = lat;
        e.t0  = cyc;
        exp_q.push_back(e);
    endtask

    // Raise start after one edge; the following edge accepts it.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] r, input logic x, input int lat);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(posedge clk);
        expect_op(r, x, lat);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] r, input logic x, input int lat);
        issue(ta, tb_v, r, x, lat);
        drain(tag);
    endtask

    // Monitor: counts cycles on the falling edge and checks every done pulse.
    initial begin : monitor
        exp_t e;
        int   busy_cnt;
        logic prev_done;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!reset) begin
                busy_cnt = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end
            if (prev_done) begin
                check("done_pulse_width", {31'b0, bus.done}, 32'd0);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.result, e.res);
                    check("exception", {31'b0, bus.exception}, {31'b0, e.exc});
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
                end
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    initial begin : driver
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'h0);
        check("reset_exception", {31'b0, bus.exception}, 32'd0);
        reset = 1'b1;

        // Normal quotients: q[25]=1 and q[25]=0 paths, round-up, signs.
        run("6/2",     32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
        run("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
        run("2/1.5",   32'h40000000, 32'h3FC00000, 32'h3FAAAAAB, 1'b0, 28);
        run("3/2",     32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, 28);
        run("-6/2",    32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28);
        run("1/1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28);

        // Range limits.
        run("ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 28);
        run("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 28);

        // Special operands take the short path.
        run("-1/0",    32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2);
        run("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 2);
        run("inf/inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 2);
        run("5/-inf",  32'h40A00000, 32'hFF800000, 32'h80000000, 1'b1, 2);
        run("1/nan",   32'h3F800000, 32'h7FA00000, 32'h7FC00000, 1'b1, 2);

        // A start pulse while busy is ignored and inputs are not re-sampled.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        drain("ignored_start");
        repeat (5) @(negedge clk);
        check("result_hold", bus.result, 32'h3EAAAAAB);

        // start held high: second operation accepted 29 cycles after the first.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(posedge clk);
        expect_op(32'h40400000, 1'b0, 28);
        #1;
        bus.a = 32'h40000000;
        bus.b = 32'h3FC00000;
        repeat (29) @(posedge clk);
        expect_op(32'h3FAAAAAB, 1'b0, 28);
        #1 bus.start = 1'b0;
        drain("back_to_back");

        // Reset mid-operation clears everything at once; no done follows.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'h0);
        check("abort_exception", {31'b0, bus.exception}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        run("after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);

        repeat (40) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
